// File: rtl/regex_stream_matcher.sv
// rtl/regex_stream_matcher.sv - streaming checker for (A B^n C S)* D symbol strings; optional stats via REGEX_STATS_EN
module regex_stream_matcher #(
  parameter int SYM_W   = 2,
  parameter int SYM_A   = 0,
  parameter int SYM_B   = 1,
  parameter int SYM_C   = 2,
  parameter int SYM_D   = 3,
  parameter int COUNT_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic               sym_valid,
  input  logic [SYM_W-1:0]   symbol_in,
  input  logic               last_symbol,
  output logic               done,
  output logic               result,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [CNT_W-1:0]   reject_cnt
);

  typedef enum logic [2:0] {IDLE, GA, GB, GC, SA, SD, SX, REJ} state_t;

  localparam logic [SYM_W-1:0]   CODE_A = SYM_A[SYM_W-1:0];
  localparam logic [SYM_W-1:0]   CODE_B = SYM_B[SYM_W-1:0];
  localparam logic [SYM_W-1:0]   CODE_C = SYM_C[SYM_W-1:0];
  localparam logic [SYM_W-1:0]   CODE_D = SYM_D[SYM_W-1:0];
  localparam logic [COUNT_W-1:0] B_MAX  = '1;
  localparam logic [COUNT_W-1:0] B_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] bcnt_q, bcnt_d;
  logic [COUNT_W-1:0] n_ref_q, n_ref_d;
  logic               s_is_d_q, s_is_d_d;   // first group's S: 0 = A, 1 = D X
  logic [SYM_W-1:0]   x_ref_q, x_ref_d;
  logic               rep_q, rep_d;
  logic               done_d, result_d;
  logic               is_a, is_b, is_c, is_d;

  assign is_a = (symbol_in == CODE_A);
  assign is_b = (symbol_in == CODE_B);
  assign is_c = (symbol_in == CODE_C);
  assign is_d = (symbol_in == CODE_D);

  // Next-state and verdict logic; repeated groups are compared against the first group's shape
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    n_ref_d  = n_ref_q;
    s_is_d_d = s_is_d_q;
    x_ref_d  = x_ref_q;
    rep_d    = rep_q;
    done_d   = 1'b0;
    result_d = 1'b0;
    if (sym_valid) begin
      if (last_symbol) begin
        done_d   = 1'b1;
        result_d = is_d && (state_q == IDLE || state_q == SA || state_q == SX);
        state_d  = IDLE;
        bcnt_d   = '0;
        n_ref_d  = '0;
        s_is_d_d = 1'b0;
        x_ref_d  = '0;
        rep_d    = 1'b0;
      end else begin
        state_d = REJ;
        case (state_q)
          IDLE: if (is_a) begin
            state_d = GA;
            bcnt_d  = '0;
          end
          GA: if (is_b) begin
            state_d = GB;
            bcnt_d  = B_ONE;
          end
          GB: begin
            if (is_b) begin
              // no wrap at saturation, and a repeated group may never exceed the reference run
              if (bcnt_q != B_MAX && !(rep_q && bcnt_q >= n_ref_q)) begin
                state_d = GB;
                bcnt_d  = bcnt_q + B_ONE;
              end
            end else if (is_c) begin
              if (!rep_q || bcnt_q == n_ref_q) begin
                state_d = GC;
                if (!rep_q) n_ref_d = bcnt_q;
              end
            end
          end
          GC: begin
            if (is_a && (!rep_q || !s_is_d_q)) begin
              state_d = SA;
              if (!rep_q) s_is_d_d = 1'b0;
            end else if (is_d && (!rep_q || s_is_d_q)) begin
              state_d = SD;
              if (!rep_q) s_is_d_d = 1'b1;
            end
          end
          SD: if ((is_b || is_c || is_d) && (!rep_q || symbol_in == x_ref_q)) begin
            state_d = SX;
            if (!rep_q) x_ref_d = symbol_in;
          end
          SA, SX: if (is_a) begin
            state_d = GA;
            bcnt_d  = '0;
            rep_d   = 1'b1;
          end
          default: state_d = REJ;
        endcase
      end
    end
  end

  // State, group reference and registered verdict
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q  <= IDLE;
      bcnt_q   <= '0;
      n_ref_q  <= '0;
      s_is_d_q <= 1'b0;
      x_ref_q  <= '0;
      rep_q    <= 1'b0;
      done     <= 1'b0;
      result   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      n_ref_q  <= n_ref_d;
      s_is_d_q <= s_is_d_d;
      x_ref_q  <= x_ref_d;
      rep_q    <= rep_d;
      done     <= done_d;
      result   <= result_d;
    end
  end

`ifdef REGEX_STATS_EN
  // Verdict statistics, wrapping modulo 2^CNT_W
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      match_cnt  <= '0;
      reject_cnt <= '0;
    end else if (done) begin
      if (result) match_cnt  <= match_cnt + 1'b1;
      else        reject_cnt <= reject_cnt + 1'b1;
    end
  end
`else
  assign match_cnt  = '0;
  assign reject_cnt = '0;
`endif

endmodule
